// File: rtl/traffic_sensor_conditioner.sv
// Lane detector conditioner: 2-flop sync, debounce and gap-hold per lane.
// Optional vehicle counters enabled by defining TSC_CAR_COUNT_EN.

module tsc_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
`ifdef TSC_CAR_COUNT_EN
    output logic o_new_car,
`endif
    output logic o_present
);

    localparam int MAXC = (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                          DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] L_DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] L_HOLD     = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] L_ONE      = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PRESENT,
        HOLD
    } state_t;

    logic          r_ff1;
    logic          r_ff2;
    state_t        r_state;
    state_t        w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic          r_tx;
    logic          w_tx_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
        end else begin
            r_ff1 <= i_raw;
            r_ff2 <= r_ff1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_tx    <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (r_ff2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_n = PRESENT;
                        w_cnt_n   = '0;
                    end else begin
                        w_state_n = ARM;
                        w_cnt_n   = L_ONE;
                    end
                end
            end
            ARM: begin
                if (!r_ff2) begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                end else if (r_cnt == L_DEB_LAST) begin
                    w_state_n = PRESENT;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + L_ONE;
                end
            end
            PRESENT: begin
                if (!r_ff2) begin
                    if (HOLD_CYCLES == 0) begin
                        w_state_n = IDLE;
                        w_cnt_n   = '0;
                    end else begin
                        w_state_n = HOLD;
                        w_cnt_n   = L_ONE;
                    end
                end
            end
            HOLD: begin
                // Returning traffic during the gap is the same vehicle
                if (r_ff2) begin
                    w_state_n = PRESENT;
                    w_cnt_n   = '0;
                end else if (r_cnt == L_HOLD) begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + L_ONE;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    assign w_tx_n    = (w_state_n == PRESENT) || (w_state_n == HOLD);
    assign o_present = r_tx;

`ifdef TSC_CAR_COUNT_EN
    assign o_new_car = ((r_state == IDLE) || (r_state == ARM)) &&
                       (w_state_n == PRESENT);
`endif

endmodule

module traffic_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
`ifdef TSC_CAR_COUNT_EN
    ,
    parameter int COUNT_W         = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sa_raw,
    input  logic               sb_raw,
`ifdef TSC_CAR_COUNT_EN
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] count_a,
    output logic [COUNT_W-1:0] count_b,
`endif
    output logic               TA,
    output logic               TB
);

`ifdef TSC_CAR_COUNT_EN
    logic               w_new_a;
    logic               w_new_b;
    logic [COUNT_W-1:0] r_count_a;
    logic [COUNT_W-1:0] r_count_b;
`endif

    tsc_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_lane_a (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (sa_raw),
`ifdef TSC_CAR_COUNT_EN
        .o_new_car(w_new_a),
`endif
        .o_present(TA)
    );

    tsc_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_lane_b (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (sb_raw),
`ifdef TSC_CAR_COUNT_EN
        .o_new_car(w_new_b),
`endif
        .o_present(TB)
    );

`ifdef TSC_CAR_COUNT_EN
    // Clear has priority; counts stick at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count_a <= '0;
            r_count_b <= '0;
        end else if (cnt_clr) begin
            r_count_a <= '0;
            r_count_b <= '0;
        end else begin
            if (w_new_a && (r_count_a != '1))
                r_count_a <= r_count_a + COUNT_W'(1);
            if (w_new_b && (r_count_b != '1))
                r_count_b <= r_count_b + COUNT_W'(1);
        end
    end

    assign count_a = r_count_a;
    assign count_b = r_count_b;
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: vector table, reference model,
// async reset and (with TSC_CAR_COUNT_EN) vehicle counter sequences.

module tb_traffic_sensor_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int CMAX = 255;

    logic clk;
    logic rst;
    logic sa_raw;
    logic sb_raw;
    logic TA;
    logic TB;
`ifdef TSC_CAR_COUNT_EN
    logic       cnt_clr;
    logic [7:0] count_a;
    logic [7:0] count_b;
`endif

    traffic_sensor_conditioner dut (
        .clk    (clk),
        .rst    (rst),
        .sa_raw (sa_raw),
        .sb_raw (sb_raw),
`ifdef TSC_CAR_COUNT_EN
        .cnt_clr(cnt_clr),
        .count_a(count_a),
        .count_b(count_b),
`endif
        .TA     (TA),
        .TB     (TB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // Reference model: synchroniser pipe plus run-length occupancy rules
    bit m_s1[2];
    bit m_s2[2];
    bit m_occ[2];
    int m_hi[2];
    int m_lo[2];
    int m_cnt[2];

    typedef struct {
        logic a;
        logic b;
        logic ea;
        logic eb;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int l = 0; l < 2; l++) begin
            m_s1[l]  = 0;
            m_s2[l]  = 0;
            m_occ[l] = 0;
            m_hi[l]  = 0;
            m_lo[l]  = 0;
            m_cnt[l] = 0;
        end
    endfunction

    function automatic void model_edge(input logic a, input logic b,
                                       input logic c);
        bit raw[2];
        raw[0] = a;
        raw[1] = b;
        for (int l = 0; l < 2; l++) begin
            bit s;
            bit newcar;
            s      = m_s2[l];
            newcar = 0;
            if (s) begin
                m_lo[l] = 0;
                m_hi[l]++;
                if (!m_occ[l] && m_hi[l] >= DEB) begin
                    m_occ[l] = 1;
                    newcar   = 1;
                end
            end else begin
                m_hi[l] = 0;
                if (m_occ[l]) begin
                    m_lo[l]++;
                    if (m_lo[l] > HOLD) begin
                        m_occ[l] = 0;
                        m_lo[l]  = 0;
                    end
                end
            end
            if (c) m_cnt[l] = 0;
            else if (newcar && m_cnt[l] < CMAX) m_cnt[l]++;
            m_s2[l] = m_s1[l];
            m_s1[l] = raw[l];
        end
    endfunction

    task automatic step(input logic a, input logic b, input logic c);
        @(negedge clk);
        sa_raw = a;
        sb_raw = b;
`ifdef TSC_CAR_COUNT_EN
        cnt_clr = c;
`endif
        @(posedge clk);
        model_edge(a, b, c);
        #1;
    endtask

    task automatic push(input int n, input logic a, input logic b,
                        input int ta_on, input int ta_off,
                        input int tb_on, input int tb_off);
        vec_t v;
        for (int j = 0; j < n; j++) begin
            v.a  = a;
            v.b  = b;
            v.ea = (j >= ta_on) && (j < ta_off);
            v.eb = (j >= tb_on) && (j < tb_off);
            tbl.push_back(v);
        end
    endtask

    task automatic car_a(input logic clr_at_entry);
        for (int j = 0; j < 6; j++) step(1'b1, 1'b0, clr_at_entry && j == 5);
        for (int j = 0; j < 12; j++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic ra;
        logic rb;
        int   run_a;
        int   run_b;
        int   waited;

        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        sa_raw  = 1'b0;
        sb_raw  = 1'b0;
`ifdef TSC_CAR_COUNT_EN
        cnt_clr = 1'b0;
`endif
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_TA", TA, 0);
        check("reset_TB", TB, 0);
`ifdef TSC_CAR_COUNT_EN
        check("reset_count_a", count_a, 0);
        check("reset_count_b", count_b, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("post_reset_TA", TA, 0);
        check("post_reset_TB", TB, 0);

        // glitch, hold-high, short gap, long gap, simultaneous lanes
        push(2,  1'b1, 1'b0, 99, 99, 99, 99);
        push(6,  1'b0, 1'b0, 99, 99, 99, 99);
        push(10, 1'b1, 1'b0, 5,  99, 99, 99);
        push(5,  1'b0, 1'b0, 0,  99, 99, 99);
        push(5,  1'b1, 1'b0, 0,  99, 99, 99);
        push(20, 1'b0, 1'b0, 0,  10, 99, 99);
        push(8,  1'b1, 1'b1, 5,  99, 5,  99);
        push(12, 1'b0, 1'b0, 0,  10, 0,  10);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].a, tbl[i].b, 1'b0);
            check($sformatf("tbl%0d_TA", i), TA, tbl[i].ea);
            check($sformatf("tbl%0d_TB", i), TB, tbl[i].eb);
        end
`ifdef TSC_CAR_COUNT_EN
        check("tbl_count_a", count_a, 2);
        check("tbl_count_b", count_b, 1);
`endif

        ra    = 1'b0;
        rb    = 1'b0;
        run_a = 0;
        run_b = 0;
        for (int i = 0; i < 800; i++) begin
            logic c;
            if (run_a == 0) begin
                ra    = ~ra;
                run_a = $urandom_range(1, 14);
            end
            if (run_b == 0) begin
                rb    = ~rb;
                run_b = $urandom_range(1, 14);
            end
            run_a--;
            run_b--;
            c = ($urandom_range(0, 49) == 0);
            step(ra, rb, c);
            check("rand_TA", TA, m_occ[0]);
            check("rand_TB", TB, m_occ[1]);
`ifdef TSC_CAR_COUNT_EN
            check("rand_count_a", count_a, m_cnt[0]);
            check("rand_count_b", count_b, m_cnt[1]);
`endif
        end

        waited = 0;
        while (!TA && waited < 20) begin
            step(1'b1, 1'b1, 1'b0);
            waited++;
        end
        check("wait_TA_high", TA, 1);
        #2;
        rst    = 1'b0;
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        #1;
        check("async_rst_TA", TA, 0);
        check("async_rst_TB", TB, 0);
`ifdef TSC_CAR_COUNT_EN
        check("async_rst_count_a", count_a, 0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 6; j++) step(1'b0, 1'b0, 1'b0);
        check("after_rst_TA", TA, 0);

`ifdef TSC_CAR_COUNT_EN
        for (int k = 0; k < 3; k++) car_a(1'b0);
        check("three_cars", count_a, 3);
        for (int j = 0; j < 6; j++) begin
            step(1'b1, 1'b0, j == 5);
            if (j == 4) check("car4_pre_TA", TA, 0);
        end
        check("car4_entry_TA", TA, 1);
        check("clr_wins", count_a, 0);
        step(1'b1, 1'b0, 1'b0);
        check("clr_held", count_a, 0);
        for (int j = 0; j < 12; j++) step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 260; k++) car_a(1'b0);
        check("saturate_a", count_a, 255);
        check("saturate_b", count_b, 0);
        check("saturate_model", count_a, m_cnt[0]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
